// File: rtl/riscv_pkg.sv
// Shared constants and types for the single-issue RISC-V core.
// Holds the ISA word width, the canonical NOP, the default boot address and the fetch FSM states.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register with next-PC selection.
// Priority: redirect > hold (stall or boot) > sequential advance.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hold_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_aligned_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] pc_next;

    always_comb begin
        pc_next = pc_p0;
        if (redirect_valid_i) begin
            pc_next = redirect_aligned_i;
        end else if (!hold_i) begin
            // Unsigned add wraps 32'hFFFF_FFFC to zero.
            pc_next = pc_p0 + 32'd4;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_p0 <= RESET_PC;
        end else begin
            pc_p0 <= pc_next;
        end
    end

    assign pc_o = pc_p0;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC to the instruction memory and captures {pc, instruction}
// into the IF/ID register, handling decode stalls and execute-stage redirects.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     IMEM_WORDS = 4096
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic [XLEN-1:0] instruction_addr_o,
    input  logic [XLEN-1:0] instruction_i,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instruction_o,
    output logic            if_id_valid_o,
    output logic            fetch_misaligned_o,
    output logic            fetch_oob_o,
    output logic [XLEN-1:0] fetch_count_o
);

    // Widened by one bit so a full 4 GiB memory does not overflow the bound.
    localparam logic [XLEN:0] IMEM_BYTES = (XLEN+1)'(IMEM_WORDS) * (XLEN+1)'(4);

    fetch_state_e state, state_next;
    logic         boot_hold;
    logic         pc_hold;
    logic [XLEN-1:0] pc;

    logic [XLEN-1:0] if_id_pc_p1;
    logic [XLEN-1:0] if_id_instr_p1;
    logic            vld_p1;
    logic            misaligned_p1;
    logic [XLEN-1:0] count_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        boot_hold = (state == BOOT);
    end

    assign pc_hold = stall_i | boot_hold;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .hold_i             (pc_hold),
        .redirect_valid_i   (redirect_valid_i),
        .redirect_aligned_i ({redirect_addr_i[XLEN-1:2], 2'b00}),
        .pc_o               (pc)
    );

    // ---- IF/ID boundary ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_id_pc_p1    <= '0;
            if_id_instr_p1 <= NOP_INSTR;
            vld_p1         <= 1'b0;
            misaligned_p1  <= 1'b0;
            count_p1       <= '0;
        end else if (redirect_valid_i) begin
            if_id_pc_p1    <= pc;
            if_id_instr_p1 <= NOP_INSTR;
            vld_p1         <= 1'b0;
            misaligned_p1  <= |redirect_addr_i[1:0];
        end else if (boot_hold) begin
            // Boot edge: IF/ID stays empty while the PC settles at RESET_PC.
            if_id_pc_p1    <= '0;
            if_id_instr_p1 <= NOP_INSTR;
            vld_p1         <= 1'b0;
            misaligned_p1  <= 1'b0;
        end else if (stall_i) begin
            misaligned_p1  <= 1'b0;
        end else begin
            if_id_pc_p1    <= pc;
            if_id_instr_p1 <= instruction_i;
            vld_p1         <= 1'b1;
            misaligned_p1  <= 1'b0;
            count_p1       <= count_p1 + 32'd1;
        end
    end

    assign instruction_addr_o  = pc;
    assign if_id_pc_o          = if_id_pc_p1;
    assign if_id_instruction_o = if_id_instr_p1;
    assign if_id_valid_o       = vld_p1;
    assign fetch_misaligned_o  = misaligned_p1;
    assign fetch_count_o       = count_p1;
    assign fetch_oob_o         = ({1'b0, pc} >= IMEM_BYTES);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-issue RISC-V core. Holds the program counter and drives the word address into the combinational instruction memory. Captures the returned 32-bit instruction together with its PC into the IF/ID pipeline register. Handles decode-stage stalls and execute-stage redirects (branch/jump/flush); a redirect inserts a bubble.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 4096, instruction memory depth in 32-bit words; byte range is IMEM_WORDS*4.

Ports:
- clk_i  in  1  core clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- stall_i  in  1  hold PC and IF/ID contents this cycle.
- redirect_valid_i  in  1  replace the PC with redirect_addr_i; the instruction fetched this cycle is discarded.
- redirect_addr_i  in  32  redirect target (byte address).
- instruction_addr_o  out  32  byte address to the instruction memory; equals the PC register.
- instruction_i  in  32  instruction word returned combinationally by the instruction memory.
- if_id_pc_o  out  32  PC of the instruction held in IF/ID.
- if_id_instruction_o  out  32  instruction held in IF/ID; 32'h0000_0013 (NOP) whenever if_id_valid_o=0.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- fetch_misaligned_o  out  1  one-cycle pulse: the last accepted redirect had addr[1:0]!=0.
- fetch_oob_o  out  1  level: the PC is at or above IMEM_WORDS*4.
- fetch_count_o  out  32  number of instructions written valid into IF/ID since reset.

## Operation
- PC register: instruction_addr_o = pc, driven straight from the register with no combinational path from any input.
- Priority per edge: reset > redirect > stall > advance.
- Redirect: pc <= {redirect_addr_i[31:2],2'b00}. IF/ID valid <= 0, instr <= NOP, if_id_pc_o <= current pc. fetch_misaligned_o <= |redirect_addr_i[1:0]. A redirect overrides a simultaneous stall_i.
- Stall (no redirect): pc, IF/ID and fetch_count_o all hold; fetch_misaligned_o <= 0.
- Advance: pc <= pc + 32'd4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0. IF/ID <= {pc, instruction_i, valid=1}. fetch_count_o increments, wrapping at 2^32. fetch_misaligned_o <= 0.
- Out-of-bounds: fetch_oob_o = (pc >= IMEM_WORDS*4), combinational from pc. Fetch continues regardless; the memory aliases and trap handling is downstream.
- State machine: two states, BOOT and RUN.
  - Reset enters BOOT. In BOOT, IF/ID stays invalid for one edge.
  - BOOT -> RUN on the first edge after rst_i deasserts, independent of stall_i.
  - The PC does not advance in BOOT, so the first valid instruction is the one at RESET_PC.

## Timing
- Reset values: pc = RESET_PC, state = BOOT, if_id_pc_o = 0, if_id_instruction_o = NOP, if_id_valid_o = 0, fetch_misaligned_o = 0, fetch_count_o = 0. fetch_oob_o follows RESET_PC.
- Reset is asynchronous: asserting rst_i mid-stream forces all of the above immediately, without waiting for a clock edge. Release is on a clock edge.
- Latency: an instruction at address A appears in IF/ID one edge after pc == A with no stall.
- Steady state: one instruction per cycle.
- Redirect penalty: one bubble. The target's instruction becomes valid in IF/ID two edges after the edge where redirect_valid_i is sampled.
- stall_i asserted for N cycles freezes outputs for N edges. There is no skid and nothing is lost.

## Structure
- Shared package riscv_pkg: the NOP constant 32'h0000_0013, the default RESET_PC, XLEN = 32, the fetch state enum {BOOT, RUN}.
- One natural sub-module: pc_reg (PC register plus next-PC mux with redirect/stall/advance priority). The IF/ID register and counter stay in the top.

## Test plan
- Reset release, no stall: memory holds 0x11,0x22,0x33 at 0,4,8. Required sequence:
  - IF/ID valid = 0 for the first edge.
  - Then {pc,instr} = {0,0x11}, {4,0x22}, {8,0x33}.
  - fetch_count_o = 3.
- Stall: assert stall_i for 3 cycles while IF/ID holds pc = 4. Required: pc stays 8, IF/ID stays {4,0x22}, fetch_count_o is unchanged. Then resume with {8,0x33}.
- Redirect with stall, misaligned target: redirect to 0x102 while stall_i = 1. Required:
  - Next edge: valid = 0, instr = NOP, pc = 0x100, fetch_misaligned_o = 1 for exactly one cycle.
  - Following edge: {0x100, mem[64]} valid.
- Wrap and out-of-bounds: redirect to 0xFFFF_FFFC. Required: fetch_oob_o = 1, and after the instruction at 0xFFFF_FFFC is captured valid, pc = 0 and fetch_oob_o = 0.
- Mid-stream reset: assert rst_i between clock edges while running. Required, immediately: pc = RESET_PC, valid = 0, count = 0. After release, the boot sequence of the first scenario repeats exactly.
